// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store request at a time, RV32I width/sign rules, WAIT_STATES wait cycles.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of aligning them.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        w_accept;
   logic        w_commit;

   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [2:0]  r_funct3;

   logic        w_we;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [2:0]  w_funct3;
   logic [AW-1:0] w_idx;
   logic        w_oor;
   logic        w_mis;
   logic        w_fault;
   logic        w_wr;
   logic [3:0]  w_be;
   logic [31:0] w_wlane;
   logic [31:0] w_word;

   logic [31:0] r_rdata;
   logic        r_err;

   logic [31:0] r_mem [DEPTH_WORDS];

   function automatic logic f3_bad(input logic we, input logic [2:0] f3);
      if (we) return (f3 > 3'd2);
      return (f3 == 3'b011) || (f3[2:1] == 2'b11);
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return a[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lane(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                            input logic [31:0] word);
      logic [7:0]  bt;
      logic [15:0] hw;
      bt = word[{a, 3'b000} +: 8];
      hw = a[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  return {{24{bt[7]}}, bt};
         3'b001:  return {{16{hw[15]}}, hw};
         3'b100:  return {24'b0, bt};
         3'b101:  return {16'b0, hw};
         default: return word;
      endcase
   endfunction

   // With no wait states the commit happens on the accepting edge, so it must see the live request.
   assign w_we     = (r_state == IDLE) ? req_we     : r_we;
   assign w_addr   = (r_state == IDLE) ? req_addr   : r_addr;
   assign w_wdata  = (r_state == IDLE) ? req_wdata  : r_wdata;
   assign w_funct3 = (r_state == IDLE) ? req_funct3 : r_funct3;

   assign w_idx = w_addr[AW+1:2];
   assign w_oor = ({2'b00, w_addr[31:2]} >= 32'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_TRAP_EN
   assign w_mis = ((w_funct3[1:0] == 2'b01) && w_addr[0]) ||
                  ((w_funct3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
`else
   assign w_mis = 1'b0;
`endif

   assign w_fault = f3_bad(w_we, w_funct3) || w_oor || w_mis;
   assign w_be    = store_be(w_funct3, w_addr[1:0]);
   assign w_wlane = store_lane(w_funct3, w_wdata);
   assign w_word  = r_mem[w_idx];
   assign w_wr    = w_commit && w_we && !w_fault && !rst;

   assign w_accept = (r_state == IDLE) && req_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_commit    = 1'b0;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (WAIT_STATES > 0) begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = 4'(WAIT_STATES - 1);
               end else begin
                  w_state_nxt = RESP;
                  w_commit    = 1'b1;
               end
            end
         end
         WAIT: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = RESP;
               w_commit    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we     <= req_we;
         r_addr   <= req_addr;
         r_wdata  <= req_wdata;
         r_funct3 <= req_funct3;
      end
   end

   // Response fields only change on the commit edge, so they stay frozen through RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else if (w_commit) begin
         r_err   <= w_fault;
         r_rdata <= (w_fault || w_we) ? 32'd0 : load_ext(w_funct3, w_addr[1:0], w_word);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
         end
      end
   end

   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table on a zero-wait instance, hand sequences on a three-wait instance.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        rsp_ready;

   logic        rv0, rv3, rr0, rr3, vs0, vs3, er0, er3;
   logic [31:0] rd0, rd3;
   logic        w_req_ready, w_rsp_valid, w_rsp_err;
   logic [31:0] w_rsp_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign rv0 = req_valid & ~sel;
   assign rv3 = req_valid & sel;
   assign w_req_ready = sel ? rr3 : rr0;
   assign w_rsp_valid = sel ? vs3 : vs0;
   assign w_rsp_rdata = sel ? rd3 : rd0;
   assign w_rsp_err   = sel ? er3 : er0;

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(rv0), .req_ready(rr0), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(vs0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(er0)
   );

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3)) u_dut3 (
      .clk(clk), .rst(rst), .req_valid(rv3), .req_ready(rr3), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(vs3), .rsp_ready(rsp_ready), .rsp_rdata(rd3), .rsp_err(er3)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [2:0] f3, input logic [31:0] exp_rd, input logic exp_err);
      vt.push_back('{we, addr, wdata, f3, exp_rd, exp_err});
   endtask

   // Full transaction with rsp_ready held high; lat counts negedges from the accepting edge to rsp_valid.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, output logic [31:0] rdata, output logic err,
                         output int lat);
      bit got;
      @(negedge clk);
      req_we = we; req_addr = addr; req_wdata = wdata; req_funct3 = f3;
      req_valid = 1'b1; rsp_ready = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (w_req_ready) begin got = 1'b1; break; end
         @(negedge clk);
      end
      if (!got) chk("req_ready timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = -1; got = 1'b0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (w_rsp_valid) begin lat = k; got = 1'b1; break; end
      end
      if (!got) chk("rsp_valid timeout", 32'd0, 32'd1);
      rdata = w_rsp_rdata;
      err   = w_rsp_err;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er;
      int          lat;

      rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
      req_wdata = 32'd0; req_funct3 = 3'd0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset req_ready dut0", 32'(rr0), 32'd1);
      chk("reset rsp_valid dut0", 32'(vs0), 32'd0);
      chk("reset rsp_rdata dut0", rd0, 32'd0);
      chk("reset rsp_err dut0", 32'(er0), 32'd0);
      chk("reset req_ready dut3", 32'(rr3), 32'd1);
      chk("reset rsp_valid dut3", 32'(vs3), 32'd0);
      rst = 1'b0;

      add(1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 0);
      add(0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 0);
      add(1, 32'h11, 32'hAAAAAA80, 3'b000, 32'h0, 0);
      add(0, 32'h11, 32'h0, 3'b000, 32'hFFFFFF80, 0);
      add(0, 32'h11, 32'h0, 3'b100, 32'h00000080, 0);
      add(0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 0);
      add(1, 32'h20, 32'h0, 3'b010, 32'h0, 0);
      add(1, 32'h22, 32'h12348001, 3'b001, 32'h0, 0);
      add(0, 32'h22, 32'h0, 3'b001, 32'hFFFF8001, 0);
      add(0, 32'h22, 32'h0, 3'b101, 32'h00008001, 0);
      add(0, 32'h20, 32'h0, 3'b010, 32'h80010000, 0);
      add(0, 32'h20, 32'h0, 3'b001, 32'h00000000, 0);
      add(0, 32'h23, 32'h0, 3'b000, 32'hFFFFFF80, 0);
      add(0, 32'h22, 32'h0, 3'b100, 32'h00000001, 0);
      add(0, 32'h100, 32'h0, 3'b010, 32'h0, 1);
      add(0, 32'h10, 32'h0, 3'b011, 32'h0, 1);
      add(0, 32'h10, 32'h0, 3'b110, 32'h0, 1);
      add(0, 32'h80000010, 32'h0, 3'b010, 32'h0, 1);
      add(1, 32'h100, 32'h11111111, 3'b010, 32'h0, 1);
      add(1, 32'h10, 32'h11111111, 3'b100, 32'h0, 1);
      add(1, 32'h10, 32'h11111111, 3'b011, 32'h0, 1);
      add(0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 0);
      add(1, 32'h13, 32'h0000005A, 3'b000, 32'h0, 0);
      add(0, 32'h13, 32'h0, 3'b100, 32'h0000005A, 0);
      add(0, 32'h13, 32'h0, 3'b000, 32'h0000005A, 0);
      add(0, 32'h10, 32'h0, 3'b010, 32'h5AAD80EF, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
      add(1, 32'h12, 32'hCAFEF00D, 3'b010, 32'h0, 1);
      add(0, 32'h10, 32'h0, 3'b010, 32'h5AAD80EF, 0);
      add(0, 32'h13, 32'h0, 3'b101, 32'h0, 1);
      add(0, 32'h13, 32'h0, 3'b010, 32'h0, 1);
      add(1, 32'h21, 32'h0000BEEF, 3'b001, 32'h0, 1);
      add(0, 32'h20, 32'h0, 3'b010, 32'h80010000, 0);
`else
      add(1, 32'h12, 32'hCAFEF00D, 3'b010, 32'h0, 0);
      add(0, 32'h10, 32'h0, 3'b010, 32'hCAFEF00D, 0);
      add(0, 32'h13, 32'h0, 3'b101, 32'h0000CAFE, 0);
      add(0, 32'h13, 32'h0, 3'b010, 32'hCAFEF00D, 0);
      add(1, 32'h21, 32'h0000BEEF, 3'b001, 32'h0, 0);
      add(0, 32'h20, 32'h0, 3'b010, 32'h8001BEEF, 0);
`endif

      for (int i = 0; i < vt.size(); i++) begin
         do_txn(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].f3, rd, er, lat);
         chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
         chk($sformatf("vec%0d err", i), 32'(er), 32'(vt[i].exp_err));
         chk($sformatf("vec%0d latency", i), 32'(lat), 32'd1);
      end
      @(negedge clk);
      chk("ws0 req_ready after handshake", 32'(w_req_ready), 32'd1);

      // Committed store survives a reset taken while the response is still pending.
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h77778888; req_funct3 = 3'b010;
      req_valid = 1'b1; rsp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("ws0 rsp_valid before reset", 32'(w_rsp_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("ws0 rsp_valid after reset", 32'(w_rsp_valid), 32'd0);
      do_txn(0, 32'h30, 32'h0, 3'b010, rd, er, lat);
      chk("ws0 committed store kept", rd, 32'h77778888);

      // Three wait states with back-pressure.
      sel = 1'b1;
      do_txn(1, 32'h10, 32'h01234567, 3'b010, rd, er, lat);
      chk("ws3 store latency", 32'(lat), 32'd4);
      chk("ws3 store err", 32'(er), 32'd0);
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1; rsp_ready = 1'b0;
      chk("ws3 req_ready idle", 32'(w_req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk($sformatf("ws3 wait%0d rsp_valid", k), 32'(w_rsp_valid), 32'd0);
         chk($sformatf("ws3 wait%0d req_ready", k), 32'(w_req_ready), 32'd0);
      end
      @(negedge clk);
      chk("ws3 rsp_valid at 4", 32'(w_rsp_valid), 32'd1);
      req_we = 1'b1; req_wdata = 32'hFFFFFFFF; req_valid = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k == 3) req_valid = 1'b0;
         chk($sformatf("ws3 hold%0d rsp_valid", k), 32'(w_rsp_valid), 32'd1);
         chk($sformatf("ws3 hold%0d rdata", k), w_rsp_rdata, 32'h01234567);
         chk($sformatf("ws3 hold%0d req_ready", k), 32'(w_req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      chk("ws3 rsp_valid after handshake", 32'(w_rsp_valid), 32'd0);
      chk("ws3 req_ready after handshake", 32'(w_req_ready), 32'd1);
      do_txn(0, 32'h10, 32'h0, 3'b010, rd, er, lat);
      chk("ws3 ignored request no write", rd, 32'h01234567);

      // Reset during WAIT drops the uncommitted store.
      do_txn(1, 32'h14, 32'h11112222, 3'b010, rd, er, lat);
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h14; req_wdata = 32'h33334444; req_funct3 = 3'b010;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("ws3 in wait req_ready", 32'(w_req_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("ws3 reset req_ready", 32'(w_req_ready), 32'd1);
      chk("ws3 reset rsp_valid", 32'(w_rsp_valid), 32'd0);
      do_txn(0, 32'h14, 32'h0, 3'b010, rd, er, lat);
      chk("ws3 dropped store", rd, 32'h11112222);
      do_txn(0, 32'h10, 32'h0, 3'b010, rd, er, lat);
      chk("ws3 old store persists", rd, 32'h01234567);
      chk("ws3 load latency", 32'(lat), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the five-stage RISC-V core. It is the slave end of the load/store request interface driven by the memory stage, and it holds word-organised data storage. It accepts one request at a time, applies RV32I load/store width and sign rules, and inserts configurable wait states. Each request gets exactly one response, returned over a valid/ready handshake.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words of storage (power of two, ≥ 4)
- WAIT_STATES, 0, extra cycles between request acceptance and response (0–15)

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data; the low bytes are used for SB/SH
- req_funct3  input  3  RV32I funct3 of the load/store
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts the response
- rsp_rdata  output  32  load result, already extended; 0 for stores and errors
- rsp_err  output  1  access fault (bad funct3, out of range, misaligned when trapping)

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, latch we, addr, wdata and funct3. Go to WAIT if WAIT_STATES>0, else go to RESP.
  - WAIT: a down-counter is loaded with WAIT_STATES-1 on acceptance. Go to RESP when the counter is 0.
  - RESP: rsp_valid=1. On rsp_ready, go to IDLE.
  - req_ready is 0 outside IDLE.
- Commit point is the edge that enters RESP. At that edge:
  - the store is written with byte enables;
  - load data is read, lane-shifted and extended;
  - rsp_rdata and rsp_err are registered.
- The response fields are held stable while in RESP.
- Word index is addr[31:2]. Any index ≥ DEPTH_WORDS is a fault: rsp_err=1, no write, rdata=0.
- Loads:
  - 000 LB: sign-extend byte addr[1:0].
  - 001 LH: sign-extend half addr[1].
  - 010 LW: full word.
  - 100 LBU, 101 LHU: zero-extend.
  - 011, 110, 111: fault.
- Stores:
  - 000 SB: byte enable 1<<addr[1:0], wdata[7:0] placed in that lane.
  - 001 SH: byte enables 0011 or 1100 selected by addr[1], wdata[15:0] placed in that half.
  - 010 SW: byte enables 1111.
  - Others: fault, no write.
- A faulting access never modifies storage.
- Storage is not cleared by reset. Contents after power-up are undefined.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE, counter 0.
- A request accepted at edge N produces rsp_valid high from edge N+1+WAIT_STATES.
- Back-to-back throughput is one request per 2+WAIT_STATES cycles when rsp_ready is held high. req_ready reasserts in the cycle after the response handshake.
- rsp_ready high while rsp_valid is low has no effect.
- Back-pressure: rsp_valid stays high and the data is held for any number of cycles until rsp_ready.
- req_valid while req_ready=0 is ignored. The requester must hold its request.
- Reset asserted mid-operation: the FSM returns to IDLE immediately. A store not yet committed is dropped. A committed store persists.
- A store followed by a load to the same address returns the new data, because there is no overlap between requests.

## Configuration
- DMEM_MISALIGN_TRAP_EN
  - Defined: a halfword access with addr[0]=1, or a word access with addr[1:0]≠0, is a fault. rsp_err=1, no write, rdata=0.
  - Undefined: misaligned addresses are silently aligned. Halfword accesses ignore addr[0]; word accesses ignore addr[1:0]. rsp_err is driven only by bad funct3 or out-of-range index.

## Test plan
- Reset, then SW 0xDEADBEEF @0x10, then LW @0x10 (WAIT_STATES=0) -> rsp_valid at N+1, rdata=0xDEADBEEF, err=0.
- SB 0x80 @0x11, then LB @0x11 and LBU @0x11 -> LB returns 0xFFFFFF80, LBU returns 0x00000080. LW @0x10 returns 0xDEAD80EF.
- SH 0x8001 @0x22, then LH @0x22 and LHU @0x22 -> LH returns 0xFFFF8001, LHU returns 0x00008001.
- WAIT_STATES=3, rsp_ready held low for 5 cycles after rsp_valid -> rsp_valid rises at N+4, data stays stable, req_ready stays 0 until the cycle after the handshake.
- LW @ 4*DEPTH_WORDS, and a load with funct3=011 -> both give err=1, rdata=0. A following LW of the previously written location is unchanged.
- SW @0x12 -> with DMEM_MISALIGN_TRAP_EN defined: err=1 and memory unchanged. Without it: err=0 and word 0x10 is overwritten.
